otter_cu_fsm_mc: RTL and testbench
==================================

OTTER_CU_FSM_MC -- requirements
Module: otter_cu_fsm_mc

Interface
REQ-001 SHALL have parameter CRYPTO_CYCLES, default 4, EXECUTE cycles per ENCRY in counted mode (legal 1..2^CNT_W-1).
REQ-002 SHALL have parameter COP_HANDSHAKE, default 0: 0 = fixed-count ENCRY, 1 = ENCRY ends on CU_COP_DONE.
REQ-003 SHALL have parameter COP_TIMEOUT, default 255, last legal EXECUTE count in handshake mode before abort (legal 0..2^CNT_W-1).
REQ-004 SHALL have parameter LOAD_WAIT, default 1, WB cycles per LOAD (legal >=1).
REQ-005 SHALL have parameter CNT_W, default 8, width of crypto_count and the WB counter.
REQ-006 SHALL have ports, clock and reset first: CU_CLK in 1 clock; CU_RESET_N in 1 reset.
REQ-007 The block SHALL use one clock, CU_CLK, and CU_RESET_N SHALL be an asynchronous, active-low reset.
REQ-008 SHALL have inputs: CU_INT 1 irq; CU_prevINT 1 latched irq; CU_OPCODE 7 IR[6:0]; CU_FUNC3 3 IR[14:12]; CU_FUNC12 12 IR[31:20]; CU_COP_DONE 1 coprocessor done.
REQ-009 SHALL have outputs, all 1 bit: CU_PCWRITE; CU_REGWRITE; CU_MEMWRITE; CU_MEMREAD1 (ifetch); CU_MEMREAD2 (data read); CU_intTaken; CU_csrWrite; CU_intCLR; CU_COP_START (start pulse); CU_COP_ERR (timeout pulse).
REQ-010 SHALL have output crypto_count, CNT_W bits, the current ENCRY EXECUTE-cycle index.

Function
REQ-011 States SHALL be FETCH, EXECUTE, WB, INTER; all outputs except crypto_count SHALL be combinational from state, counters, and inputs.
REQ-012 Opcodes SHALL be: LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111, BRANCH 1100011, LOAD 0000011, STORE 0100011, OP_IMM 0010011, OP 0110011, SYSTEM 1110011, ENCRY 1011011.
REQ-013 MRET SHALL be SYSTEM & FUNC3=000 & FUNC12=0x302.
REQ-014 "Exit" SHALL mean: next state = INTER if CU_INT|CU_prevINT, else FETCH.
REQ-015 In FETCH: MEMREAD1=1, all other outputs 0; next state EXECUTE.
REQ-016 In EXECUTE with a single-cycle opcode (not LOAD/ENCRY): PCWRITE=1; intCLR=1; then exit.
REQ-017 In that case, REGWRITE=1 except for BRANCH, STORE, MRET or an unlisted opcode.
REQ-018 In that case, MEMWRITE=1 for STORE, and csrWrite=1 for SYSTEM with FUNC3=001.
REQ-019 In EXECUTE with LOAD: MEMREAD2=1, PCWRITE=0, REGWRITE=0; WB counter cleared; next state WB.
REQ-020 WB SHALL last exactly LOAD_WAIT cycles, with outputs 0 on all but the last cycle.
REQ-021 On the last WB cycle: REGWRITE=1, PCWRITE=1, intCLR=1; then exit.
REQ-022 On the first ENCRY EXECUTE cycle (crypto_count=0), COP_START SHALL be 1 for exactly that cycle.
REQ-023 Each non-final ENCRY EXECUTE cycle SHALL increment crypto_count and stay in EXECUTE, with PCWRITE=REGWRITE=0.
REQ-024 In counted mode, the final ENCRY cycle SHALL be crypto_count=CRYPTO_CYCLES-1.
REQ-025 In handshake mode, the final ENCRY cycle SHALL be the first EXECUTE cycle with COP_DONE=1; DONE on the START cycle SHALL be accepted.
REQ-026 On a normal ENCRY finish: PCWRITE=1, REGWRITE=1, intCLR=1; crypto_count->0; then exit.
REQ-027 In handshake mode, on crypto_count=COP_TIMEOUT with COP_DONE=0: COP_ERR=1 for one cycle, PCWRITE=1, REGWRITE=0, intCLR=1; crypto_count->0; then exit.
REQ-028 When COP_DONE=1 and a timeout occur in the same cycle, DONE SHALL win and COP_ERR SHALL stay 0.
REQ-029 COP_DONE SHALL be ignored outside ENCRY EXECUTE and in counted mode.
REQ-030 In INTER: PCWRITE=1, intTaken=1, intCLR=1; next state FETCH.
REQ-031 CU_INT SHALL be sampled only at exit points; ENCRY and multi-cycle WB SHALL NOT be interrupted mid-sequence.
REQ-032 CRYPTO_CYCLES=1 SHALL give START and finish in the same cycle.
REQ-033 CU_OPCODE SHALL be held stable by upstream for the duration of an instruction.

Reset
REQ-034 While CU_RESET_N=0: state=FETCH, crypto_count=0, WB counter=0, and all outputs forced to 0 (including MEMREAD1).
REQ-035 On release of CU_RESET_N, the first rising edge SHALL see FETCH with MEMREAD1=1.
REQ-036 A reset assertion mid-ENCRY or mid-WB SHALL abort immediately with no PCWRITE/REGWRITE pulse.

Verification
REQ-037 Defaults, OP with INT=0: FETCH->EXECUTE->FETCH; EXECUTE cycle PCWRITE=REGWRITE=intCLR=1.
REQ-038 CRYPTO_CYCLES=4, ENCRY, INT=1 throughout: crypto_count 0,1,2,3; START at count 0; PCWRITE/REGWRITE only at count 3; then INTER with intTaken=1; then FETCH.
REQ-039 COP_HANDSHAKE=1, COP_TIMEOUT=5: DONE at count 2 -> finish, REGWRITE=1, ERR=0; DONE never -> ERR=1 at count 5, REGWRITE=0; DONE at count 5 -> normal finish.
REQ-040 LOAD_WAIT=3, LOAD: MEMREAD2=1 in EXECUTE; 3 WB cycles; REGWRITE=PCWRITE=1 only in the 3rd.
REQ-041 BRANCH, STORE and MRET each give REGWRITE=0; STORE gives MEMWRITE=1; CSRRW (SYSTEM, FUNC3=001) gives csrWrite=1.
REQ-042 CU_RESET_N low asynchronously at ENCRY count 2: outputs 0 immediately; count=0; FETCH after release.

Source files
------------

// File: rtl/otter_cu_fsm_mc.sv
// ---------------------------------------------------------------------------
// otter_cu_fsm_mc
//
// Multi-cycle control-unit FSM for the OTTER RISC-V core. It has four states:
// FETCH, EXECUTE, WB and INTER. It also sequences the ENCRY coprocessor
// instruction. That instruction runs either for a fixed count
// (COP_HANDSHAKE=0) or until CU_COP_DONE arrives, with a timeout
// (COP_HANDSHAKE=1).
//
// Ports
//   CU_CLK, CU_RESET_N : clock and asynchronous active-low reset
//   CU_INT, CU_prevINT : live and latched interrupt requests
//   CU_OPCODE          : IR[6:0]
//   CU_FUNC3           : IR[14:12]
//   CU_FUNC12          : IR[31:20]
//   CU_COP_DONE        : coprocessor done
//   CU_PCWRITE, CU_REGWRITE, CU_MEMWRITE, CU_MEMREAD1 (ifetch),
//   CU_MEMREAD2 (data read), CU_intTaken, CU_csrWrite, CU_intCLR,
//   CU_COP_START (start pulse), CU_COP_ERR (timeout pulse)
//   crypto_count       : current ENCRY EXECUTE-cycle index (registered)
//
// Handshake with the coprocessor:
//   CU_COP_START is high for exactly one cycle, the first ENCRY EXECUTE cycle.
//   In handshake mode, the coprocessor raises CU_COP_DONE in any ENCRY
//   EXECUTE cycle, including the START cycle. That cycle becomes the final
//   cycle. CU_COP_DONE is ignored everywhere else.
//
// Every output except crypto_count is combinational. Each one is gated by
// CU_RESET_N, so all outputs drop to 0 as soon as reset asserts.
// ---------------------------------------------------------------------------
module otter_cu_fsm_mc #(
    parameter int CRYPTO_CYCLES = 4,
    parameter int COP_HANDSHAKE = 0,
    parameter int COP_TIMEOUT   = 255,
    parameter int LOAD_WAIT     = 1,
    parameter int CNT_W         = 8
) (
    input  logic             CU_CLK,
    input  logic             CU_RESET_N,
    input  logic             CU_INT,
    input  logic             CU_prevINT,
    input  logic [6:0]       CU_OPCODE,
    input  logic [2:0]       CU_FUNC3,
    input  logic [11:0]      CU_FUNC12,
    input  logic             CU_COP_DONE,
    output logic             CU_PCWRITE,
    output logic             CU_REGWRITE,
    output logic             CU_MEMWRITE,
    output logic             CU_MEMREAD1,
    output logic             CU_MEMREAD2,
    output logic             CU_intTaken,
    output logic             CU_csrWrite,
    output logic             CU_intCLR,
    output logic             CU_COP_START,
    output logic             CU_COP_ERR,
    output logic [CNT_W-1:0] crypto_count
);

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_ENCRY  = 7'b1011011;

    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] CRYPTO_LAST = CNT_W'(CRYPTO_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(COP_TIMEOUT);
    localparam logic [CNT_W-1:0] WB_LAST     = CNT_W'(LOAD_WAIT - 1);

    typedef enum logic [1:0] {
        ST_FETCH   = 2'd0,
        ST_EXECUTE = 2'd1,
        ST_WB      = 2'd2,
        ST_INTER   = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] crypto_count_q, crypto_count_d;
    logic [CNT_W-1:0] wb_cnt_q, wb_cnt_d;

    // Raw (ungated) output decode.
    logic pc_write, reg_write, mem_write, mem_read1, mem_read2;
    logic int_taken, csr_write, int_clr, cop_start, cop_err;

    logic   is_mret;
    state_t exit_state;

    assign is_mret    = (CU_OPCODE == OP_SYSTEM) && (CU_FUNC3 == 3'b000) &&
                        (CU_FUNC12 == 12'h302);
    // An interrupt is only ever taken at an instruction boundary.
    assign exit_state = (CU_INT || CU_prevINT) ? ST_INTER : ST_FETCH;

    always_ff @(posedge CU_CLK or negedge CU_RESET_N) begin
        if (!CU_RESET_N) begin
            state_q        <= ST_FETCH;
            crypto_count_q <= '0;
            wb_cnt_q       <= '0;
        end else begin
            state_q        <= state_d;
            crypto_count_q <= crypto_count_d;
            wb_cnt_q       <= wb_cnt_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        crypto_count_d = crypto_count_q;
        wb_cnt_d       = wb_cnt_q;
        pc_write       = 1'b0;
        reg_write      = 1'b0;
        mem_write      = 1'b0;
        mem_read1      = 1'b0;
        mem_read2      = 1'b0;
        int_taken      = 1'b0;
        csr_write      = 1'b0;
        int_clr        = 1'b0;
        cop_start      = 1'b0;
        cop_err        = 1'b0;

        case (state_q)
            ST_FETCH: begin
                mem_read1 = 1'b1;
                state_d   = ST_EXECUTE;
            end

            ST_EXECUTE: begin
                case (CU_OPCODE)
                    OP_LOAD: begin
                        mem_read2 = 1'b1;
                        wb_cnt_d  = '0;
                        state_d   = ST_WB;
                    end

                    OP_ENCRY: begin
                        cop_start = (crypto_count_q == '0);
                        if (COP_HANDSHAKE != 0) begin
                            // DONE takes priority over a timeout in the same cycle.
                            if (CU_COP_DONE) begin
                                pc_write       = 1'b1;
                                reg_write      = 1'b1;
                                int_clr        = 1'b1;
                                crypto_count_d = '0;
                                state_d        = exit_state;
                            end else if (crypto_count_q == TIMEOUT_CNT) begin
                                cop_err        = 1'b1;
                                pc_write       = 1'b1;
                                int_clr        = 1'b1;
                                crypto_count_d = '0;
                                state_d        = exit_state;
                            end else begin
                                crypto_count_d = crypto_count_q + CNT_ONE;
                            end
                        end else begin
                            if (crypto_count_q == CRYPTO_LAST) begin
                                pc_write       = 1'b1;
                                reg_write      = 1'b1;
                                int_clr        = 1'b1;
                                crypto_count_d = '0;
                                state_d        = exit_state;
                            end else begin
                                crypto_count_d = crypto_count_q + CNT_ONE;
                            end
                        end
                    end

                    default: begin
                        // Single-cycle instructions. Unlisted opcodes still
                        // advance the PC but write nothing.
                        pc_write = 1'b1;
                        int_clr  = 1'b1;
                        state_d  = exit_state;
                        case (CU_OPCODE)
                            OP_LUI, OP_AUIPC, OP_JAL, OP_JALR,
                            OP_OPIMM, OP_OP:  reg_write = 1'b1;
                            OP_STORE:         mem_write = 1'b1;
                            OP_SYSTEM: begin
                                reg_write = !is_mret;
                                csr_write = (CU_FUNC3 == 3'b001);
                            end
                            default:          reg_write = 1'b0;
                        endcase
                    end
                endcase
            end

            ST_WB: begin
                if (wb_cnt_q == WB_LAST) begin
                    reg_write = 1'b1;
                    pc_write  = 1'b1;
                    int_clr   = 1'b1;
                    wb_cnt_d  = '0;
                    state_d   = exit_state;
                end else begin
                    wb_cnt_d = wb_cnt_q + CNT_ONE;
                end
            end

            ST_INTER: begin
                pc_write  = 1'b1;
                int_taken = 1'b1;
                int_clr   = 1'b1;
                state_d   = ST_FETCH;
            end

            default: state_d = ST_FETCH;
        endcase
    end

    assign CU_PCWRITE   = pc_write  & CU_RESET_N;
    assign CU_REGWRITE  = reg_write & CU_RESET_N;
    assign CU_MEMWRITE  = mem_write & CU_RESET_N;
    assign CU_MEMREAD1  = mem_read1 & CU_RESET_N;
    assign CU_MEMREAD2  = mem_read2 & CU_RESET_N;
    assign CU_intTaken  = int_taken & CU_RESET_N;
    assign CU_csrWrite  = csr_write & CU_RESET_N;
    assign CU_intCLR    = int_clr   & CU_RESET_N;
    assign CU_COP_START = cop_start & CU_RESET_N;
    assign CU_COP_ERR   = cop_err   & CU_RESET_N;
    assign crypto_count = crypto_count_q;

endmodule

// File: tb/tb_otter_cu_fsm_mc.sv
// ---------------------------------------------------------------------------
// tb_otter_cu_fsm_mc
//
// Bench for otter_cu_fsm_mc, built from two instances that share all inputs.
//   u_cnt : counted ENCRY (CRYPTO_CYCLES=4), LOAD_WAIT=3
//   u_hs  : handshake ENCRY, COP_TIMEOUT=5, LOAD_WAIT=1
//
// Each driver call applies one cycle of inputs just after the rising edge.
// It then pushes the output vector that the selected instance must show in
// that cycle. On every falling edge, the monitor pops one entry and compares
// it against the selected instance.
//
// Vector layout, from MSB to LSB:
//   {PCWRITE, REGWRITE, MEMWRITE, MEMREAD1, MEMREAD2, intTaken, csrWrite,
//    intCLR, COP_START, COP_ERR, crypto_count[7:0]}
// ---------------------------------------------------------------------------
module tb_otter_cu_fsm_mc;

  localparam int W = 18;

  localparam logic [W-1:0] PC = 18'h20000;
  localparam logic [W-1:0] RW = 18'h10000;
  localparam logic [W-1:0] MW = 18'h08000;
  localparam logic [W-1:0] R1 = 18'h04000;
  localparam logic [W-1:0] R2 = 18'h02000;
  localparam logic [W-1:0] IT = 18'h01000;
  localparam logic [W-1:0] CS = 18'h00800;
  localparam logic [W-1:0] CL = 18'h00400;
  localparam logic [W-1:0] ST = 18'h00200;
  localparam logic [W-1:0] ER = 18'h00100;
  localparam logic [W-1:0] Z  = 18'h00000;

  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] OPR    = 7'b0110011;
  localparam logic [6:0] SYSTEM = 7'b1110011;
  localparam logic [6:0] ENCRY  = 7'b1011011;
  localparam logic [6:0] BOGUS  = 7'b0000000;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b0;
  logic        cu_int = 1'b0, cu_prev = 1'b0, cop_done = 1'b0;
  logic [6:0]  opcode = 7'd0;
  logic [2:0]  func3 = 3'd0;
  logic [11:0] func12 = 12'd0;
  logic        sel = 1'b0;

  logic a_pc, a_rw, a_mw, a_r1, a_r2, a_it, a_cs, a_cl, a_st, a_er;
  logic b_pc, b_rw, b_mw, b_r1, b_r2, b_it, b_cs, b_cl, b_st, b_er;
  logic [7:0] a_cnt, b_cnt;

  otter_cu_fsm_mc #(.CRYPTO_CYCLES(4), .COP_HANDSHAKE(0), .COP_TIMEOUT(255),
                    .LOAD_WAIT(3), .CNT_W(8)) u_cnt (
    .CU_CLK(clk), .CU_RESET_N(rst_n), .CU_INT(cu_int), .CU_prevINT(cu_prev),
    .CU_OPCODE(opcode), .CU_FUNC3(func3), .CU_FUNC12(func12),
    .CU_COP_DONE(cop_done),
    .CU_PCWRITE(a_pc), .CU_REGWRITE(a_rw), .CU_MEMWRITE(a_mw),
    .CU_MEMREAD1(a_r1), .CU_MEMREAD2(a_r2), .CU_intTaken(a_it),
    .CU_csrWrite(a_cs), .CU_intCLR(a_cl), .CU_COP_START(a_st),
    .CU_COP_ERR(a_er), .crypto_count(a_cnt));

  otter_cu_fsm_mc #(.CRYPTO_CYCLES(4), .COP_HANDSHAKE(1), .COP_TIMEOUT(5),
                    .LOAD_WAIT(1), .CNT_W(8)) u_hs (
    .CU_CLK(clk), .CU_RESET_N(rst_n), .CU_INT(cu_int), .CU_prevINT(cu_prev),
    .CU_OPCODE(opcode), .CU_FUNC3(func3), .CU_FUNC12(func12),
    .CU_COP_DONE(cop_done),
    .CU_PCWRITE(b_pc), .CU_REGWRITE(b_rw), .CU_MEMWRITE(b_mw),
    .CU_MEMREAD1(b_r1), .CU_MEMREAD2(b_r2), .CU_intTaken(b_it),
    .CU_csrWrite(b_cs), .CU_intCLR(b_cl), .CU_COP_START(b_st),
    .CU_COP_ERR(b_er), .crypto_count(b_cnt));

  logic [W-1:0] vec_a, vec_b;
  assign vec_a = {a_pc, a_rw, a_mw, a_r1, a_r2, a_it, a_cs, a_cl, a_st, a_er, a_cnt};
  assign vec_b = {b_pc, b_rw, b_mw, b_r1, b_r2, b_it, b_cs, b_cl, b_st, b_er, b_cnt};

  // scoreboard
  logic [W:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int cyc_no = 0;

  always @(negedge clk) begin
    logic [W:0]   e;
    logic [W-1:0] act;
    cyc_no++;
    if (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      act = e[W] ? vec_b : vec_a;
      checks++;
      if (act !== e[W-1:0]) begin
        errors++;
        $display("FAIL cycle %0d dut=%s: got %05h expected %05h", cyc_no,
                 e[W] ? "hs" : "cnt", act, e[W-1:0]);
      end
    end
  end

  // driver: one cycle of inputs plus the expected outputs for that cycle
  task automatic cyc(input logic rst, input logic [6:0] op, input logic [2:0] f3,
                     input logic [11:0] f12, input logic [1:0] irq,
                     input logic done, input logic [W-1:0] exp);
    @(posedge clk);
    #1;
    rst_n    = rst;
    opcode   = op;
    func3    = f3;
    func12   = f12;
    cu_prev  = irq[1];
    cu_int   = irq[0];
    cop_done = done;
    exp_q.push_back({sel, exp});
  endtask

  // shorthand for one plain cycle: reset released, FUNC fields and DONE at 0
  task automatic c(input logic [6:0] op, input logic [1:0] irq, input logic [W-1:0] exp);
    cyc(1'b1, op, 3'd0, 12'd0, irq, 1'b0, exp);
  endtask

  initial begin
    // counted instance
    sel = 1'b0;
    cyc(1'b0, OPR, 3'd0, 12'd0, 2'b00, 1'b0, Z);
    cyc(1'b0, OPR, 3'd0, 12'd0, 2'b00, 1'b1, Z);
    c(OPR, 2'b00, R1);                     // first cycle after release: FETCH
    c(OPR, 2'b00, PC | RW | CL);
    c(BRANCH, 2'b00, R1);
    c(BRANCH, 2'b00, PC | CL);
    c(STORE, 2'b00, R1);
    c(STORE, 2'b00, PC | MW | CL);
    cyc(1'b1, SYSTEM, 3'b000, 12'h302, 2'b00, 1'b0, R1);           // MRET
    cyc(1'b1, SYSTEM, 3'b000, 12'h302, 2'b00, 1'b0, PC | CL);
    cyc(1'b1, SYSTEM, 3'b001, 12'h300, 2'b00, 1'b0, R1);           // CSRRW
    cyc(1'b1, SYSTEM, 3'b001, 12'h300, 2'b00, 1'b0, PC | RW | CS | CL);
    c(BOGUS, 2'b00, R1);
    c(BOGUS, 2'b00, PC | CL);
    c(LUI, 2'b01, R1);
    c(LUI, 2'b01, PC | RW | CL);
    c(LUI, 2'b00, PC | IT | CL);           // INTER
    c(OPR, 2'b10, R1);                     // latched irq only
    c(OPR, 2'b10, PC | RW | CL);
    c(OPR, 2'b00, PC | IT | CL);
    c(LOAD, 2'b00, R1);
    c(LOAD, 2'b01, R2);                    // irq ignored mid-sequence
    c(LOAD, 2'b01, Z);
    c(LOAD, 2'b00, Z);
    c(LOAD, 2'b00, PC | RW | CL);
    c(ENCRY, 2'b01, R1);
    cyc(1'b1, ENCRY, 3'd0, 12'd0, 2'b01, 1'b1, ST);                // DONE ignored
    c(ENCRY, 2'b01, 18'd1);
    c(ENCRY, 2'b01, 18'd2);
    c(ENCRY, 2'b01, PC | RW | CL | 18'd3);
    c(ENCRY, 2'b01, PC | IT | CL);
    c(ENCRY, 2'b00, R1);
    c(ENCRY, 2'b00, ST);
    c(ENCRY, 2'b00, 18'd1);
    cyc(1'b0, ENCRY, 3'd0, 12'd0, 2'b00, 1'b0, Z);                 // async abort at count 2
    cyc(1'b0, ENCRY, 3'd0, 12'd0, 2'b00, 1'b0, Z);
    c(OPR, 2'b00, R1);
    c(OPR, 2'b00, PC | RW | CL);

    // handshake instance
    sel = 1'b1;
    cyc(1'b0, OPR, 3'd0, 12'd0, 2'b00, 1'b0, Z);
    cyc(1'b0, OPR, 3'd0, 12'd0, 2'b00, 1'b0, Z);
    c(ENCRY, 2'b00, R1);
    c(ENCRY, 2'b00, ST);
    c(ENCRY, 2'b00, 18'd1);
    cyc(1'b1, ENCRY, 3'd0, 12'd0, 2'b00, 1'b1, PC | RW | CL | 18'd2);
    c(ENCRY, 2'b00, R1);
    cyc(1'b1, ENCRY, 3'd0, 12'd0, 2'b00, 1'b1, ST | PC | RW | CL); // DONE on START
    c(ENCRY, 2'b00, R1);
    c(ENCRY, 2'b00, ST);
    for (int i = 1; i < 5; i++) c(ENCRY, 2'b00, 18'(i));
    c(ENCRY, 2'b00, ER | PC | CL | 18'd5);                         // timeout
    c(ENCRY, 2'b00, R1);
    c(ENCRY, 2'b00, ST);
    for (int i = 1; i < 5; i++) c(ENCRY, 2'b00, 18'(i));
    cyc(1'b1, ENCRY, 3'd0, 12'd0, 2'b00, 1'b1, PC | RW | CL | 18'd5); // DONE beats timeout
    cyc(1'b1, OPR, 3'd0, 12'd0, 2'b00, 1'b1, R1);
    cyc(1'b1, OPR, 3'd0, 12'd0, 2'b00, 1'b1, PC | RW | CL);
    c(LOAD, 2'b00, R1);
    c(LOAD, 2'b00, R2);
    c(LOAD, 2'b00, PC | RW | CL);

    // drain the scoreboard, with a bounded wait
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
